// File: rtl/conv_layer_sched.sv
// Layer / output-channel / input-channel sequencer for the convolution accelerator.
// Steps WGT -> (IMG -> COMP)* -> STORE per output channel and reports busy/done.
module conv_layer_sched #(
  parameter int NUM_LAYERS  = 3,
  parameter int ROWS_PER_IC = 45,
  parameter int IC_L0       = 1,
  parameter int IC_LN       = 64,
  parameter int OC_NUM      = 64
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic       i_wgt_done,
  input  logic       i_img_loaded,
  input  logic       i_row_done,
  input  logic       i_store_done,
  output logic [1:0] o_state,
  output logic [1:0] o_current_layer,
  output logic [5:0] o_current_ic,
  output logic [5:0] o_current_oc,
  output logic       o_valid,
  output logic       o_busy,
  output logic       o_done
);

  localparam logic [5:0] ROW_LAST   = 6'(ROWS_PER_IC - 1);
  localparam logic [5:0] IC0_LAST   = 6'(IC_L0 - 1);
  localparam logic [5:0] ICN_LAST   = 6'(IC_LN - 1);
  localparam logic [5:0] OC_LAST    = 6'(OC_NUM - 1);
  localparam logic [1:0] LAYER_LAST = 2'(NUM_LAYERS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WGT, S_IMG, S_COMP, S_STORE, S_FIN
  } state_t;

  state_t     r_state, w_next;
  logic [1:0] r_layer, w_layer;
  logic [5:0] r_ic, w_ic, r_oc, w_oc, r_row, w_row;
  logic [5:0] w_ic_last;
  logic [1:0] r_phase;
  logic       r_valid, r_busy, r_done;

  // IMG and COMP share the "image" phase code seen by the buffers.
  function automatic logic [1:0] phase_of(state_t s);
    case (s)
      S_IMG, S_COMP: return 2'd1;
      S_WGT:         return 2'd2;
      S_STORE:       return 2'd3;
      default:       return 2'd0;
    endcase
  endfunction

  assign w_ic_last = (r_layer == 2'd0) ? IC0_LAST : ICN_LAST;

  always_comb begin
    w_next  = r_state;
    w_layer = r_layer;
    w_ic    = r_ic;
    w_oc    = r_oc;
    w_row   = r_row;
    case (r_state)
      S_IDLE: if (i_start) begin
        w_next  = S_WGT;
        w_layer = '0;
        w_ic    = '0;
        w_oc    = '0;
        w_row   = '0;
      end
      S_WGT: if (i_wgt_done) begin
        w_next = S_IMG;
        w_ic   = '0;
      end
      S_IMG: if (i_img_loaded) begin
        w_next = S_COMP;
        w_row  = '0;
      end
      S_COMP: if (i_row_done) begin
        if (r_row == ROW_LAST) begin
          w_row = '0;
          if (r_ic < w_ic_last) begin
            w_ic   = r_ic + 6'd1;
            w_next = S_IMG;
          end else begin
            w_next = S_STORE;
          end
        end else begin
          w_row = r_row + 6'd1;
        end
      end
      S_STORE: if (i_store_done) begin
        if (r_oc < OC_LAST) begin
          w_oc   = r_oc + 6'd1;
          w_ic   = '0;
          w_next = S_WGT;
        end else if (r_layer < LAYER_LAST) begin
          w_layer = r_layer + 2'd1;
          w_oc    = '0;
          w_ic    = '0;
          w_next  = S_WGT;
        end else begin
          w_next = S_FIN;
        end
      end
      S_FIN: begin
        w_next  = S_IDLE;
        w_layer = '0;
        w_ic    = '0;
        w_oc    = '0;
        w_row   = '0;
      end
      default: w_next = S_IDLE;
    endcase
    // Abort overrides whatever transition the events above selected.
    if (i_abort) begin
      w_next  = S_IDLE;
      w_layer = '0;
      w_ic    = '0;
      w_oc    = '0;
      w_row   = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_layer <= '0;
      r_ic    <= '0;
      r_oc    <= '0;
      r_row   <= '0;
      r_phase <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_layer <= w_layer;
      r_ic    <= w_ic;
      r_oc    <= w_oc;
      r_row   <= w_row;
      r_phase <= phase_of(w_next);
      r_valid <= (w_next == S_COMP);
      r_busy  <= (w_next != S_IDLE);
      r_done  <= (w_next == S_FIN);
    end
  end

  assign o_state         = r_phase;
  assign o_current_layer = r_layer;
  assign o_current_ic    = r_ic;
  assign o_current_oc    = r_oc;
  assign o_valid         = r_valid;
  assign o_busy          = r_busy;
  assign o_done          = r_done;

endmodule

// File: tb/tb_conv_layer_sched.sv
// Bench for conv_layer_sched: a run is expanded into its flat list of expected
// steps by nested loops, and the DUT must walk that list one matching event at a time.
module tb_conv_layer_sched;
  localparam int TL = 2, TR = 4, TIC0 = 1, TICN = 3, TOC = 3;
  localparam int K_WGT = 0, K_IMG = 1, K_COMP = 2, K_STORE = 3, K_FIN = 4;

  logic clk = 1'b0, rstn = 1'b0;
  logic start = 1'b0, abort = 1'b0, wgt = 1'b0, img = 1'b0, row = 1'b0, store = 1'b0;
  logic [1:0] st, layer;
  logic [5:0] ic, oc;
  logic valid, busy, done;

  conv_layer_sched #(.NUM_LAYERS(TL), .ROWS_PER_IC(TR), .IC_L0(TIC0), .IC_LN(TICN), .OC_NUM(TOC)) dut (
    .clk(clk), .rstn(rstn), .i_start(start), .i_abort(abort), .i_wgt_done(wgt),
    .i_img_loaded(img), .i_row_done(row), .i_store_done(store), .o_state(st),
    .o_current_layer(layer), .o_current_ic(ic), .o_current_oc(oc), .o_valid(valid),
    .o_busy(busy), .o_done(done));

  always #5 clk = ~clk;

  typedef struct { int kind; int layer; int ic; int oc; } step_t;
  step_t plan[$];
  int    ptr = 0;
  bit    m_active = 1'b0;
  int    n_cmp = 0, n_err = 0;

  function automatic step_t mk(int k, int l, int i, int o);
    step_t s;
    s.kind = k; s.layer = l; s.ic = i; s.oc = o;
    return s;
  endfunction

  task automatic build_plan();
    int icmax;
    plan.delete();
    for (int l = 0; l < TL; l++)
      for (int o = 0; o < TOC; o++) begin
        icmax = (l == 0) ? TIC0 : TICN;
        plan.push_back(mk(K_WGT, l, 0, o));
        for (int i = 0; i < icmax; i++) begin
          plan.push_back(mk(K_IMG, l, i, o));
          for (int r = 0; r < TR; r++) plan.push_back(mk(K_COMP, l, i, o));
        end
        plan.push_back(mk(K_STORE, l, icmax - 1, o));
      end
    plan.push_back(mk(K_FIN, TL - 1, ((TL == 1) ? TIC0 : TICN) - 1, TOC - 1));
  endtask

  function automatic int phase_code(int k);
    case (k)
      K_WGT:   return 2;
      K_IMG:   return 1;
      K_COMP:  return 1;
      K_STORE: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic bit event_for(int k);
    case (k)
      K_WGT:   return wgt;
      K_IMG:   return img;
      K_COMP:  return row;
      K_STORE: return store;
      default: return 1'b0;
    endcase
  endfunction

  // Reference model and per-cycle compare.
  initial forever begin
    logic [18:0] exp_v, act_v;
    step_t e;
    @(posedge clk or negedge rstn);
    if (!rstn) m_active = 1'b0;
    else if (m_active) begin
      if (abort || plan[ptr].kind == K_FIN) m_active = 1'b0;
      else if (event_for(plan[ptr].kind)) ptr++;
    end else if (start && !abort) begin
      build_plan();
      ptr = 0;
      m_active = 1'b1;
    end
    #1;
    if (m_active) begin
      e = plan[ptr];
      exp_v = {2'(phase_code(e.kind)), 2'(e.layer), 6'(e.ic), 6'(e.oc),
               e.kind == K_COMP, 1'b1, e.kind == K_FIN};
    end else exp_v = '0;
    act_v = {st, layer, ic, oc, valid, busy, done};
    n_cmp++;
    if (act_v !== exp_v) begin
      n_err++;
      $display("FAIL cycle_check t=%0t actual st=%0d L=%0d ic=%0d oc=%0d v=%b b=%b d=%b required st=%0d L=%0d ic=%0d oc=%0d v=%b b=%b d=%b",
               $time, act_v[18:17], act_v[16:15], act_v[14:9], act_v[8:3], act_v[2], act_v[1], act_v[0],
               exp_v[18:17], exp_v[16:15], exp_v[14:9], exp_v[8:3], exp_v[2], exp_v[1], exp_v[0]);
    end
  end

  task automatic chk(string name, int act, int exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp_v);
    end
  endtask

  task automatic cyc(bit s, bit a, bit w, bit im, bit r, bit sd);
    start = s; abort = a; wgt = w; img = im; row = r; store = sd;
    @(negedge clk);
    start = 0; abort = 0; wgt = 0; img = 0; row = 0; store = 0;
  endtask

  task automatic rows(int n);
    repeat (n) cyc(0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    int nrow, nst, ndone, guard;
    bit done_after_store, last_store;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_state", st, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Directed walk through layer 0 and into layer 1.
    cyc(1, 0, 0, 0, 0, 0);
    chk("start_state", st, 2);
    chk("start_busy", busy, 1);
    chk("start_idx", {layer, ic, oc}, 0);
    chk("start_done", done, 0);
    chk("plan_len", plan.size(), 73);
    cyc(0, 0, 1, 0, 0, 0);
    chk("img_valid", valid, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("comp_state", st, 1);
    chk("comp_valid", valid, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0);
    chk("spurious_state", st, 1);
    rows(TR);
    chk("store_state", st, 3);
    chk("store_ic", ic, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("oc_step", oc, 1);
    chk("oc_step_state", st, 2);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("row_in_img", valid, 0);
    cyc(0, 0, 0, 1, 1, 0);
    chk("img_row_together", valid, 1);
    rows(TR - 1);
    chk("row_cnt_zero", st, 1);
    rows(1);
    chk("row_cnt_store", st, 3);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    rows(TR);
    cyc(0, 0, 0, 0, 0, 1);
    chk("layer_step", layer, 1);
    chk("layer_oc0", oc, 0);
    cyc(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < TICN; i++) begin
      chk("ic_index", ic, i);
      cyc(0, 0, 0, 1, 0, 0);
      rows(TR);
    end
    chk("last_ic_store", st, 3);
    chk("last_ic_hold", ic, TICN - 1);
    cyc(0, 1, 0, 0, 0, 0);
    chk("abort_busy", busy, 0);
    chk("abort_idx", {layer, ic, oc}, 0);

    // Reset asserted in STORE clears outputs without a clock edge.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    rows(TR);
    chk("pre_reset_state", st, 3);
    rstn = 1'b0;
    #1;
    chk("async_reset_state", st, 0);
    chk("async_reset_busy", busy, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Full run answered by the right event each cycle.
    nrow = 0; nst = 0; ndone = 0; guard = 0; done_after_store = 0;
    cyc(1, 0, 0, 0, 0, 0);
    while (busy && guard < 1000) begin
      guard++;
      last_store = 0;
      if (st == 2) cyc(0, 0, 1, 0, 0, 0);
      else if (st == 1 && !valid) cyc(0, 0, 0, 1, 0, 0);
      else if (st == 1) begin nrow++; cyc(0, 0, 0, 0, 1, 0); end
      else if (st == 3) begin nst++; last_store = 1; cyc(0, 0, 0, 0, 0, 1); end
      else cyc(0, 0, 0, 0, 0, 0);
      if (done) begin ndone++; done_after_store = last_store; end
    end
    chk("run_timeout", guard < 1000, 1);
    chk("run_done_count", ndone, 1);
    chk("run_done_after_store", done_after_store, 1);
    chk("run_rows", nrow, TR * TOC * (TIC0 + (TL - 1) * TICN));
    chk("run_stores", nst, TOC * TL);
    chk("run_busy_end", busy, 0);

    // Random event soup.
    for (int c = 0; c < 8000; c++) begin
      if ($urandom_range(999) == 0) begin
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
      end else
        cyc($urandom_range(99) < 8, $urandom_range(999) < 3, $urandom_range(99) < 35,
            $urandom_range(99) < 35, $urandom_range(99) < 40, $urandom_range(99) < 35);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/conv_layer_sched.md
Name: conv_layer_sched

Overview:
- Top-level sequencer for the convolution accelerator. It walks layer -> output channel -> input channel and drives the phase and index buses (state, current_layer, current_ic, current_oc) consumed by the input image buffer, the weight buffer and the PE array.
- It advances on completion events from those blocks: weights loaded, image loaded (tlast), row done, result stored.
- It reports busy/done to the AXI-lite control path.

Parameters:
- NUM_LAYERS, 3, number of layers executed per run (1..4).
- ROWS_PER_IC, 45, image rows processed per input channel.
- IC_L0, 1, input channels in layer 0.
- IC_LN, 64, input channels in layers 1..NUM_LAYERS-1.
- OC_NUM, 64, output channels per layer (1..64).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle run request
- i_abort  in  1  synchronous abort: return to IDLE next cycle
- i_wgt_done  in  1  pulse: weights for current oc loaded
- i_img_loaded  in  1  pulse: current ic image fully received (DMA tlast accepted)
- i_row_done  in  1  pulse: one image row pushed through PEs
- i_store_done  in  1  pulse: current oc result sent to DMA
- o_state  out  2  phase: 0 idle, 1 image load, 2 weight load, 3 result store
- o_current_layer  out  2  layer index
- o_current_ic  out  6  input channel index
- o_current_oc  out  6  output channel index
- o_valid  out  1  high during COMPUTE (PE array enabled)
- o_busy  out  1  high in any state except IDLE
- o_done  out  1  one-cycle pulse after last layer completes

Behaviour:
- All outputs are registered. Reset (async, rstn=0) forces:
  - FSM to IDLE;
  - o_state=0, all indices 0, row counter 0;
  - o_valid=0, o_busy=0, o_done=0.
- Reset mid-run aborts immediately. No pulse is emitted and no in-flight event is remembered.
- FSM states: IDLE, WGT, IMG, COMP, STORE, FIN.
- o_state mapping: IDLE=0, IMG=1, COMP=1, WGT=2, STORE=3, FIN=0.
- IDLE:
  - i_start=1 -> WGT next cycle.
  - layer, ic, oc and row counters are cleared on the same edge.
- WGT: i_wgt_done -> IMG; ic=0.
- IMG: i_img_loaded -> COMP; row counter=0.
- COMP (o_valid=1), on each i_row_done:
  - row counter increments.
  - On the pulse where row counter = ROWS_PER_IC-1, row counter wraps to 0, then:
    - if ic < IC_MAX-1: ic++, -> IMG;
    - else: -> STORE.
  - IC_MAX = IC_L0 when layer=0, IC_LN otherwise.
- STORE, on i_store_done:
  - if oc < OC_NUM-1: oc++, ic=0, -> WGT;
  - else if layer < NUM_LAYERS-1: layer++, oc=0, ic=0, -> WGT;
  - else: -> FIN.
- FIN: o_done=1 for exactly one cycle, then -> IDLE. o_busy is low from the IDLE cycle onward.
- Event filtering:
  - Completion pulses arriving in a non-matching state are ignored, not queued.
  - Example: i_row_done during IMG has no effect; i_img_loaded during COMP has no effect.
  - If several pulses arrive together, only the one matching the current state acts.
- i_start while o_busy=1 is ignored.
- i_abort has priority over every transition. It takes effect on the next edge: -> IDLE, indices cleared, no o_done.
- Index latency:
  - o_current_ic and o_current_oc change on the same edge as the state transition that consumes them.
  - They are stable for the whole phase.
- Width rules:
  - ic/oc are 6-bit; IC_LN=64 and OC_NUM=64 reach 63 max, no overflow.
  - Row counter is 6-bit and compared against ROWS_PER_IC-1.
- Tracing: o_done is asserted the cycle after the final i_store_done.

Test Plan:
- Reset, start: rstn low for 3 cycles, then i_start -> o_state=2, o_busy=1, all indices 0 one cycle later; o_done=0.
- Layer 0, one oc:
  - wgt_done, then img_loaded -> o_state=1, o_valid=1.
  - 45 row_done pulses -> o_state=3, o_current_ic stays 0.
  - store_done -> o_current_oc=1, o_state=2.
- Layer 1 ic wrap:
  - After 64 oc of layer 0, o_current_layer=1.
  - Per oc: 64 × (img_loaded + 45 row_done), with o_current_ic stepping 0..63, then STORE.
  - Row 44 of ic 63 -> STORE, not IMG.
- Full run, reduced params (NUM_LAYERS=2, IC_LN=2, OC_NUM=2, ROWS_PER_IC=3):
  - o_done pulses exactly once, one cycle after the last store_done.
  - o_busy falls the next cycle; the total event count matches the nested-loop product.
- Spurious events:
  - row_done in IMG, store_done in COMP, and i_start while busy -> state and indices unchanged.
  - Simultaneous img_loaded+row_done in IMG -> only the transition to COMP occurs, row counter stays 0.
- Abort/reset mid-run:
  - i_abort in COMP at ic=5 -> IDLE next cycle, indices 0, o_done never pulses.
  - rstn low in STORE -> outputs 0 immediately, before the next clk edge.
